// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU function codes, MIPS opcode/funct constants and the decoded-control struct.
// Used by alu_decode (producer) and alu_issue_stage (consumer).
package mips_pkg;
    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_SRA  = 4'hA;
    localparam logic [3:0] ALU_SLLV = 4'hB;
    localparam logic [3:0] ALU_SRLV = 4'hC;
    localparam logic [3:0] ALU_SRAV = 4'hD;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_kind_e;

    typedef struct packed {
        logic [3:0] f;
        logic [4:0] shamt;
        logic       use_imm;
        imm_kind_e  imm_kind;
        logic       zero_a;
        logic       illegal;
    } ctrl_t;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS op/funct to ALU control translator.
// Ports: op, funct, shamt in; ctrl out (function, shift amount, B-select, imm kind, A-zero, illegal).
module alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] shamt,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl   = '0;
        ctrl.f = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: ctrl.f = ALU_ADD;
                    F_SUB, F_SUBU: ctrl.f = ALU_SUB;
                    F_AND:  ctrl.f = ALU_AND;
                    F_OR:   ctrl.f = ALU_OR;
                    F_XOR:  ctrl.f = ALU_XOR;
                    F_NOR:  ctrl.f = ALU_NOR;
                    F_SLT:  ctrl.f = ALU_SLT;
                    F_SLTU: ctrl.f = ALU_SLTU;
                    F_SLL:  begin ctrl.f = ALU_SLL; ctrl.shamt = shamt; end
                    F_SRL:  begin ctrl.f = ALU_SRL; ctrl.shamt = shamt; end
                    F_SRA:  begin ctrl.f = ALU_SRA; ctrl.shamt = shamt; end
                    F_SLLV: ctrl.f = ALU_SLLV;
                    F_SRLV: ctrl.f = ALU_SRLV;
                    F_SRAV: ctrl.f = ALU_SRAV;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OP_BEQ, OP_BNE: ctrl.f = ALU_SUB;
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: ctrl.use_imm = 1'b1;
            OP_SLTI:  begin ctrl.f = ALU_SLT;  ctrl.use_imm = 1'b1; end
            OP_SLTIU: begin ctrl.f = ALU_SLTU; ctrl.use_imm = 1'b1; end
            OP_ANDI:  begin ctrl.f = ALU_AND; ctrl.use_imm = 1'b1; ctrl.imm_kind = IMM_ZEXT; end
            OP_ORI:   begin ctrl.f = ALU_OR;  ctrl.use_imm = 1'b1; ctrl.imm_kind = IMM_ZEXT; end
            OP_XORI:  begin ctrl.f = ALU_XOR; ctrl.use_imm = 1'b1; ctrl.imm_kind = IMM_ZEXT; end
            OP_LUI: begin
                ctrl.f        = ALU_OR;
                ctrl.use_imm  = 1'b1;
                ctrl.imm_kind = IMM_LUI;
                ctrl.zero_a   = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register feeding the ALU (a, b, f, shamt) with stall/flush and RAW forwarding.
// Ports: clk/reset/stall/flush control; id_* decode-stage instruction and register data;
// mem_*/wb_* forwarding sources; ex_* registered ALU controls and forwarded operands.
module alu_issue_stage
    import mips_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int FWD_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [5:0]      id_op,
    input  logic [5:0]      id_funct,
    input  logic [4:0]      id_shamt,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    input  logic [15:0]     id_imm,
    input  logic            mem_regwrite,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_f,
    output logic [4:0]      ex_shamt,
    output logic            ex_illegal
);
    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [3:0]      f;
        logic [4:0]      shamt;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic            fwd_a;
        logic            fwd_b;
    } ex_reg_t;

    ctrl_t           ctrl;
    ex_reg_t         cap, ex_d, ex_q;
    logic [XLEN-1:0] imm_ext;
    logic            mem_a, mem_b, wb_a, wb_b;

    alu_decode u_dec (.op(id_op), .funct(id_funct), .shamt(id_shamt), .ctrl(ctrl));

    always_comb begin
        imm_ext = ctrl.imm_kind == IMM_LUI  ? XLEN'({id_imm, 16'h0}) :
                  ctrl.imm_kind == IMM_ZEXT ? XLEN'(id_imm) :
                  {{(XLEN-16){id_imm[15]}}, id_imm};
        cap         = '0;
        cap.valid   = 1'b1;
        cap.illegal = ctrl.illegal;
        cap.f       = ctrl.f;
        cap.shamt   = ctrl.shamt;
        cap.rs      = id_rs;
        cap.rt      = id_rt;
        // Only genuine register sources are eligible for forwarding.
        cap.fwd_a   = !ctrl.illegal && !ctrl.zero_a;
        cap.fwd_b   = !ctrl.illegal && !ctrl.use_imm;
        cap.a       = cap.fwd_a ? id_rs_data : '0;
        cap.b       = ctrl.illegal ? '0 : ctrl.use_imm ? imm_ext : id_rt_data;
        ex_d = flush || (!stall && !id_valid) ? '0 : stall ? ex_q : cap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    // EX/MEM wins over MEM/WB; register 0 never forwards.
    always_comb begin
        mem_a = FWD_EN != 0 && ex_q.fwd_a && mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_q.rs;
        mem_b = FWD_EN != 0 && ex_q.fwd_b && mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_q.rt;
        wb_a  = FWD_EN != 0 && ex_q.fwd_a && wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_q.rs;
        wb_b  = FWD_EN != 0 && ex_q.fwd_b && wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_q.rt;
        ex_a  = mem_a ? mem_result : wb_a ? wb_result : ex_q.a;
        ex_b  = mem_b ? mem_result : wb_b ? wb_result : ex_q.b;
    end

    assign ex_valid   = ex_q.valid;
    assign ex_illegal = ex_q.illegal;
    assign ex_f       = ex_q.f;
    assign ex_shamt   = ex_q.shamt;
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that drives the 32-bit ALU's operand/function interface (a, b, f, shamt).
- Decodes MIPS opcode/funct into the 4-bit ALU function code and selects the B operand (register or extended immediate).
- Registers the decoded result with stall/flush control.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB onto the registered register operands.

Parameters:
- XLEN, 32, datapath width
- FWD_EN, 1, 0 disables forwarding (ex_a/ex_b come straight from the registered file data)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold the ID/EX register contents
- flush  in  1  insert a bubble on the next edge
- id_valid  in  1  decode-stage instruction is valid
- id_op  in  6  opcode field
- id_funct  in  6  funct field
- id_shamt  in  5  shamt field
- id_rs, id_rt  in  5  source register numbers
- id_rs_data, id_rt_data  in  XLEN  register-file read data
- id_imm  in  16  immediate field
- mem_regwrite  in  1  EX/MEM writes a register
- mem_rd  in  5  EX/MEM destination register
- mem_result  in  XLEN  EX/MEM result
- wb_regwrite  in  1  MEM/WB writes a register
- wb_rd  in  5  MEM/WB destination register
- wb_result  in  XLEN  MEM/WB result
- ex_valid  out  1  EX-stage instruction valid
- ex_a, ex_b  out  XLEN  ALU operands after forwarding
- ex_f  out  4  ALU function code
- ex_shamt  out  5  ALU shift amount
- ex_illegal  out  1  unrecognised opcode/funct captured

Behaviour:
- Reset (async, active-high): all registered state cleared. ex_valid=0, ex_illegal=0, ex_f=AND (0000), ex_shamt=0, ex_a=ex_b=0.
- Latency: one cycle from id_* to the registered ex_* controls. Forwarding muxes are combinational on the registered values.
- Edge priority: reset > flush > stall > capture.
  - flush=1 (including with stall=1) loads a bubble: valid=0, illegal=0, f=AND, operands 0, rs/rt tags 0.
  - id_valid=0 with no stall loads the same bubble.
  - stall=1 with no flush holds every register. Forwarded outputs still track the current mem_/wb_ inputs.
- ALU function encoding (exact): AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, NOR 0101, SLT 0110, SLTU 0111, SLL 1000, SRL 1001, SRA 1010, SLLV 1011, SRLV 1100, SRAV 1101. Codes 1110 and 1111 are unused.
- R-type decode (op 000000), selecting rs/rt:
  - add/addu → ADD; sub/subu → SUB.
  - and, or, xor, nor, slt, sltu → the matching codes.
  - sll/srl/sra → SLL/SRL/SRA with shamt=id_shamt.
  - sllv/srlv/srav → SLLV/SRLV/SRAV with shamt=0.
  - Any other funct is illegal.
- I-type decode, B = immediate:
  - addi/addiu/lw/sw → ADD, sign-extended immediate.
  - slti → SLT, sign-extended; sltiu → SLTU, sign-extended.
  - andi/ori/xori → AND/OR/XOR, zero-extended.
  - lui → OR, A forced to 0, B={imm,16'h0}.
- Branch decode: beq/bne → SUB with B=rt.
- Illegal instruction:
  - Any other opcode, or an illegal funct, is captured with ex_valid=1 and ex_illegal=1.
  - f=ADD, A and B forced to 0, no forwarding.
- Forwarding, per operand, only when that operand is a register source and FWD_EN=1:
  - Source is mem_result if mem_regwrite and mem_rd≠0 and mem_rd equals the tag.
  - Otherwise wb_result if wb_regwrite and wb_rd≠0 and wb_rd equals the tag.
  - Otherwise the registered file data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
  - Immediate B and forced-zero operands are never forwarded.

Decomposition:
- Shared package mips_pkg holds ALU function code constants, opcode/funct constants and a typedef for the decoded-control struct (f, shamt, use_imm, zero_a, illegal).
- One sub-module, alu_decode: a purely combinational op/funct → control translator.
- This block holds the pipeline register and the forwarding muxes.

Test Plan:
- Reset during capture → all outputs 0 and ex_f=0000 immediately, without waiting for a clock edge.
- R-type sra, rt_data=32'hFFFFFFF0, shamt=2 → next cycle ex_f=1010, ex_shamt=2, ex_b=32'hFFFFFFF0, ex_valid=1.
- addi with imm=16'hFFFC and lui with imm=16'h1234 → ex_f=0010/ex_b=32'hFFFFFFFC, then ex_f=0001/ex_a=0/ex_b=32'h12340000.
- Forwarding: registered rs=5, rt=5; mem_rd=5/mem_result=32'hAAAA0000 and wb_rd=5/wb_result=32'h5555; both regwrite=1 → ex_a=ex_b=32'hAAAA0000. Drop mem_regwrite → both 32'h5555. mem_rd=0 → not forwarded.
- stall=1 for 3 cycles while id_* changes → ex_f/ex_shamt unchanged. Then assert stall=1 and flush=1 together → bubble (ex_valid=0).
- Opcode 6'b111111 → ex_valid=1, ex_illegal=1, ex_f=0010, ex_a=ex_b=0.
